// File: rtl/dac_serial_ctrl.sv
// Multi-channel serial DAC controller: MSB-first words over shared SCLK/SDI,
// one chip-select per DAC, shared load and clear strobes.
module dac_serial_ctrl #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 2,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_defer,
    input  logic              clr_req,
    output logic              busy,
    output logic              err,
    output logic [NUM_CH-1:0] dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_sdi,
    output logic              dac_ld_n,
    output logic              dac_clr_n
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, HOLD, GAP, LOAD, CLEAR
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     phase, phase_n;
    logic              half, half_n;
    logic [BW-1:0]     bitcnt, bitcnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic              defer, defer_n;
    logic              chok, chok_n;
    logic              clr_pend, clr_pend_n;
    logic              err_n;
    logic [NUM_CH-1:0] cs_n_n;
    logic              sclk_n, sdi_n, ld_n_n, clr_n_n;
    logic              phase_last, ch_in_ok, accept;

    assign phase_last = (phase == PW'(CLK_DIV - 1));
    assign ch_in_ok   = 32'(in_ch) < 32'(NUM_CH);
    assign in_ready   = reset & (state == IDLE) & ~clr_req & ~clr_pend;
    assign accept     = in_valid & in_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        half_n     = half;
        bitcnt_n   = bitcnt;
        sh_n       = sh;
        ch_n       = ch;
        defer_n    = defer;
        chok_n     = chok;
        clr_pend_n = clr_pend;
        err_n      = 1'b0;
        if (state != IDLE)
            phase_n = phase_last ? '0 : phase + 1'b1;
        if (clr_req && state != IDLE && state != CLEAR)
            clr_pend_n = 1'b1;
        unique case (state)
            IDLE: begin
                phase_n = '0;
                if (clr_req || clr_pend) begin
                    state_n = CLEAR;
                end else if (accept) begin
                    ch_n     = in_ch;
                    defer_n  = in_defer;
                    chok_n   = ch_in_ok;
                    sh_n     = in_data;
                    bitcnt_n = BW'(DATA_W);
                    half_n   = 1'b0;
                    err_n    = ~ch_in_ok;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (phase_last) begin
                    if (!half) begin
                        half_n = 1'b1;
                    end else begin
                        half_n   = 1'b0;
                        sh_n     = sh << 1;
                        bitcnt_n = bitcnt - 1'b1;
                        if (bitcnt == BW'(1))
                            state_n = HOLD;
                    end
                end
            end
            HOLD: if (phase_last) state_n = GAP;
            GAP: begin
                if (phase_last)
                    state_n = (chok && !defer) ? LOAD : IDLE;
            end
            LOAD: if (phase_last) state_n = IDLE;
            CLEAR: begin
                clr_pend_n = 1'b0;
                if (phase_last)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Pin values follow the next state so every pin is a flop aligned to state.
    always_comb begin
        cs_n_n = '1;
        if ((state_n == SHIFT || state_n == HOLD) && chok_n) begin
            for (int i = 0; i < NUM_CH; i++)
                if (ch_n == CH_W'(i))
                    cs_n_n[i] = 1'b0;
        end
        sclk_n  = (state_n == SHIFT) && half_n;
        sdi_n   = (state_n == SHIFT) ? sh_n[DATA_W-1] : dac_sdi;
        ld_n_n  = (state_n != LOAD);
        clr_n_n = (state_n != CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            phase    <= '0;
            half     <= 1'b0;
            bitcnt   <= '0;
            sh       <= '0;
            ch       <= '0;
            defer    <= 1'b0;
            chok     <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            half     <= half_n;
            bitcnt   <= bitcnt_n;
            sh       <= sh_n;
            ch       <= ch_n;
            defer    <= defer_n;
            chok     <= chok_n;
            clr_pend <= clr_pend_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err       <= 1'b0;
            dac_cs_n  <= '1;
            dac_sclk  <= 1'b0;
            dac_sdi   <= 1'b0;
            dac_ld_n  <= 1'b1;
            dac_clr_n <= 1'b1;
        end else begin
            err       <= err_n;
            dac_cs_n  <= cs_n_n;
            dac_sclk  <= sclk_n;
            dac_sdi   <= sdi_n;
            dac_ld_n  <= ld_n_n;
            dac_clr_n <= clr_n_n;
        end
    end

endmodule
